// File: rtl/tmds_decoder.sv
// rtl/tmds_decoder.sv - TMDS receive channel: word alignment on control-token runs plus 10b/8b decode
module tmds_decoder #(
  parameter int LOCK_CNT      = 4,
  parameter int SEARCH_WAIT   = 64,
  parameter int TOKEN_TIMEOUT = 4096
) (
  input  logic       pixel_clk,
  input  logic       rst,
  input  logic       en,
  input  logic [9:0] din,
  output logic [7:0] d,
  output logic       c0,
  output logic       c1,
  output logic       de,
  output logic       aligned,
  output logic [3:0] offset,
  output logic       err
);

  localparam int TW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(SEARCH_WAIT);
  localparam int OW = $clog2(TOKEN_TIMEOUT);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_CNT - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(SEARCH_WAIT - 1);
  localparam logic [OW-1:0] TO_LAST   = OW'(TOKEN_TIMEOUT - 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t        state;
  logic [9:0]    prev;
  logic [TW-1:0] tok_cnt;
  logic [WW-1:0] wait_cnt;
  logic [OW-1:0] to_cnt;

  logic [19:0] cat;
  logic [9:0]  w;
  logic        is_tok;
  logic [1:0]  tok_c;
  logic [7:0]  x;
  logic [7:0]  dec;
  logic [3:0]  off_inc;

  // Offset k selects bits k..k+9 of the two most recent words.
  assign cat     = {prev, din};
  assign w       = 10'(cat >> offset);
  assign off_inc = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
  assign aligned = (state == LOCKED);

  always_comb begin
    is_tok = 1'b1;
    tok_c  = 2'b00;
    case (w)
      10'b1101010100: tok_c = 2'b00;
      10'b0010101011: tok_c = 2'b01;
      10'b0101010100: tok_c = 2'b10;
      10'b1010101011: tok_c = 2'b11;
      default:        is_tok = 1'b0;
    endcase
  end

  always_comb begin
    x      = w[9] ? ~w[7:0] : w[7:0];
    dec    = 8'd0;
    dec[0] = x[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = w[8] ? (x[i] ^ x[i-1]) : ~(x[i] ^ x[i-1]);
    end
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      state    <= SEARCH;
      prev     <= '0;
      tok_cnt  <= '0;
      wait_cnt <= '0;
      to_cnt   <= '0;
      offset   <= '0;
      d        <= '0;
      c0       <= 1'b0;
      c1       <= 1'b0;
      de       <= 1'b0;
      err      <= 1'b0;
    end else begin
      prev <= din;
      err  <= 1'b0;
      if (!en) begin
        state    <= SEARCH;
        tok_cnt  <= '0;
        wait_cnt <= '0;
        to_cnt   <= '0;
        d        <= '0;
        c0       <= 1'b0;
        c1       <= 1'b0;
        de       <= 1'b0;
      end else begin
        de       <= ~is_tok;
        d        <= is_tok ? 8'd0 : dec;
        {c1, c0} <= is_tok ? tok_c : 2'b00;
        case (state)
          SEARCH: begin
            // Lock wins over an offset step landing on the same cycle.
            if (is_tok && tok_cnt == LOCK_LAST) begin
              state    <= LOCKED;
              tok_cnt  <= '0;
              wait_cnt <= '0;
              to_cnt   <= '0;
            end else if (wait_cnt == WAIT_LAST) begin
              offset   <= off_inc;
              wait_cnt <= '0;
              tok_cnt  <= '0;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
              tok_cnt  <= is_tok ? tok_cnt + 1'b1 : '0;
            end
          end
          LOCKED: begin
            if (is_tok) begin
              to_cnt <= '0;
            end else if (to_cnt == TO_LAST) begin
              err      <= 1'b1;
              state    <= SEARCH;
              offset   <= off_inc;
              to_cnt   <= '0;
              tok_cnt  <= '0;
              wait_cnt <= '0;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tmds_decoder.sv
// tb/tb_tmds_decoder.sv - directed self-checking bench for tmds_decoder
module tb_tmds_decoder;

  logic       pixel_clk = 1'b0;
  logic       rst;
  logic       en;
  logic [9:0] din;
  logic [7:0] d;
  logic       c0, c1, de, aligned, err;
  logic [3:0] offset;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [9:0] TOK0 = 10'b1101010100;
  localparam logic [9:0] TOK1 = 10'b0010101011;
  localparam logic [9:0] TOK2 = 10'b0101010100;
  localparam logic [9:0] DATA0 = 10'b0100000000;
  localparam logic [9:0] DATAF = 10'b1000000000;

  tmds_decoder dut (
    .pixel_clk(pixel_clk),
    .rst      (rst),
    .en       (en),
    .din      (din),
    .d        (d),
    .c0       (c0),
    .c1       (c1),
    .de       (de),
    .aligned  (aligned),
    .offset   (offset),
    .err      (err)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge pixel_clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #3 rst = 1'b0;
  endtask

  logic [9:0] rot3;

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    din = '0;
    rot3 = {TOK1[6:0], TOK1[9:7]};
    tick(2);
    check("rst_aligned", aligned, 0);
    check("rst_offset", offset, 0);
    check("rst_outs", {d, c0, c1, de, err}, 0);
    rst = 1'b0;

    // aligned lock on TOK0
    en = 1'b1; din = TOK0;
    tick(3);
    check("lock0_pre", aligned, 0);
    tick(1);
    check("lock0_aligned", aligned, 1);
    check("lock0_offset", offset, 0);
    check("lock0_ctl", {de, c1, c0}, 3'b000);

    // data decode
    din = DATA0; tick(1);
    check("dec00_de", de, 1);
    check("dec00_d", d, 8'h00);
    din = DATAF; tick(1);
    check("decff_d", d, 8'hFF);
    din = TOK2; tick(1);
    check("tok2_ctl", {de, c1, c0}, 3'b010);
    check("tok2_d", d, 0);

    // async reset while locked
    do_reset();
    check("arst_aligned", aligned, 0);
    check("arst_outs", {d, c0, c1, de, err}, 0);
    check("arst_offset", offset, 0);
    din = TOK0; tick(4);
    check("relock_aligned", aligned, 1);
    check("relock_offset", offset, 0);

    // timeout
    din = DATA0;
    tick(4095);
    check("to_pre_err", err, 0);
    check("to_pre_aligned", aligned, 1);
    tick(1);
    check("to_err", err, 1);
    check("to_aligned", aligned, 0);
    check("to_offset", offset, 1);
    tick(1);
    check("to_err_pulse", err, 0);

    // wrap with no tokens
    din = 10'd0;
    do_reset();
    tick(63);
    check("wrap_o0", offset, 0);
    tick(1);
    check("wrap_o1", offset, 1);
    tick(575);
    check("wrap_o9", offset, 9);
    tick(1);
    check("wrap_o0b", offset, 0);

    // misaligned lock at offset 3
    din = rot3;
    do_reset();
    tick(64);
    check("mis_o1", offset, 1);
    tick(64);
    check("mis_o2", offset, 2);
    tick(64);
    check("mis_o3", offset, 3);
    check("mis_not_yet", aligned, 0);
    tick(3);
    check("mis_pre", aligned, 0);
    tick(1);
    check("mis_aligned", aligned, 1);
    check("mis_offset", offset, 3);
    check("mis_ctl", {de, c1, c0}, 3'b001);

    // enable drop while locked
    en = 1'b0; tick(1);
    check("en_aligned", aligned, 0);
    check("en_outs", {d, c0, c1, de, err}, 0);
    check("en_offset", offset, 3);
    en = 1'b1; tick(4);
    check("en_relock", aligned, 1);
    check("en_relock_off", offset, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
